l2_fwd_stall_tracker: RTL and testbench
=======================================

# l2_fwd_stall_tracker

Holds a coherence forward that the L2 cannot service yet because its line is owned by an MSHR entry in a transient state. It wakes the forward for replay once that MSHR entry is released. The block sits directly upstream of the L2 input decoder. It drives the decoder's `fwd_stall` and `fwd_stall_ended` inputs and consumes the decoder's `set_fwd_in_from_stalled` output. It also supplies the decoder-side forward registers with the saved address and payload.

## Interface
Parameters:
- `LINE_ADDR_W`, default 28: line address width (32-bit address minus 4 offset bits).
- `PAYLOAD_W`, default 16: opaque forward payload width (coh_msg, req_id, word_mask).
- `MSHR_IDX_W`, default 2: MSHR index width.
- `CNT_W`, default 16: stall-cycle counter width.
- `TIMEOUT`, default 4096: stall-cycle count at which the watchdog trips; must be less than 2^CNT_W.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall_req` in 1: the forward in the fwd stage hit a transient MSHR entry and must be parked.
- `stall_mshr_idx` in MSHR_IDX_W: the blocking MSHR entry.
- `stall_addr` in LINE_ADDR_W: line address of the forward being parked.
- `stall_payload` in PAYLOAD_W: payload of the forward being parked.
- `mshr_release` in 1: an MSHR entry left its transient state this cycle.
- `mshr_release_idx` in MSHR_IDX_W: index of the released entry.
- `set_fwd_in_from_stalled` in 1: the decoder accepted the replay this cycle.
- `fwd_stall` out 1: a forward is parked (the block is in WAIT or READY).
- `fwd_stall_ended` out 1: the parked forward may be replayed (the block is in READY).
- `stalled_addr` out LINE_ADDR_W: saved line address.
- `stalled_payload` out PAYLOAD_W: saved payload.
- `stall_cycles` out CNT_W: cycles spent in WAIT for the current stall; saturates.
- `timeout_err` out 1: sticky watchdog flag.
- `protocol_err` out 1: sticky flag for an illegal `stall_req`.

## Operation
- There are three states: IDLE, WAIT and READY. A single entry is tracked; there is no queue.
- All outputs are registered. On reset:
  - State goes to IDLE.
  - `fwd_stall`, `fwd_stall_ended`, `timeout_err` and `protocol_err` are 0.
  - `stalled_addr`, `stalled_payload`, `stall_cycles` and the saved index are 0.
- IDLE:
  - On `stall_req`: capture address, payload and MSHR index, and clear `stall_cycles`.
  - If `mshr_release` is asserted in the same cycle with `mshr_release_idx == stall_mshr_idx`, go to READY. A simultaneous wake-up must never be lost.
  - Otherwise go to WAIT.
  - `mshr_release` in IDLE with no `stall_req` is ignored.
- WAIT:
  - On `mshr_release` with `mshr_release_idx` equal to the saved index, go to READY. Releases of other indices are ignored.
  - `stall_cycles` increments every cycle spent in WAIT, saturating at 2^CNT_W−1.
  - When `stall_cycles` reaches TIMEOUT, set `timeout_err`. The block stays in WAIT.
- READY:
  - `fwd_stall_ended` is held at 1 until `set_fwd_in_from_stalled` is asserted, then go to IDLE.
  - If `stall_req` is asserted in the same cycle as `set_fwd_in_from_stalled` (back-to-back stall), capture the new forward and apply the IDLE rules to it; the next state is WAIT or READY.
- Illegal input: `stall_req` in WAIT, or in READY without `set_fwd_in_from_stalled`:
  - Set `protocol_err`.
  - Leave the saved entry unchanged.
  - Do not change state.
- `set_fwd_in_from_stalled` outside READY has no effect.
- `timeout_err` and `protocol_err` are cleared only by `rst`.
- `rst` asserted mid-stall drops the parked forward immediately; outputs return to their reset values asynchronously.

## Timing
- `stall_req` sampled at edge N gives `fwd_stall` = 1 from cycle N+1.
- A matching `mshr_release` at edge M gives `fwd_stall_ended` = 1 from cycle M+1.
- A same-cycle `stall_req` and matching release give `fwd_stall` and `fwd_stall_ended` both = 1 at N+1.
- `set_fwd_in_from_stalled` at edge K gives `fwd_stall` = `fwd_stall_ended` = 0 at K+1, unless a back-to-back capture occurred.
- `stalled_addr` and `stalled_payload` are stable from capture until the next capture; they are not cleared on consume.
- Minimum turnaround from park to replay is 1 cycle.
- There is no combinational path from inputs to outputs.

## Test plan
- Basic wake-up:
  - Stimulus: `stall_req` with idx 2, addr 0x0ABCDEF, payload 0x1234, then `mshr_release` idx 2 after 5 cycles, then `set_fwd_in_from_stalled` 2 cycles later.
  - Required response: `fwd_stall` high for 8 cycles; `fwd_stall_ended` high for the last 2; `stall_cycles` = 5; `stalled_addr` = 0x0ABCDEF.
- Non-matching release:
  - Stimulus: park on idx 1; release idx 0 and then idx 3.
  - Required response: the block stays in WAIT and `fwd_stall_ended` stays 0. A later release of idx 1 moves it to READY.
- Same-cycle capture and release:
  - Stimulus: `stall_req` idx 3 together with `mshr_release` idx 3.
  - Required response: the next cycle has `fwd_stall` = `fwd_stall_ended` = 1 and `stall_cycles` = 0.
- Back-to-back stall:
  - Stimulus: in READY, `set_fwd_in_from_stalled` together with `stall_req` idx 0, addr 0x55.
  - Required response: the block is in WAIT with `stalled_addr` = 0x55 and `fwd_stall` staying 1.
- Watchdog, illegal request and reset:
  - Stimulus: TIMEOUT = 8; park with no release; then issue `stall_req` while in WAIT; then assert `rst` mid-WAIT.
  - Required response: `timeout_err` rises when `stall_cycles` reaches 8. `protocol_err` rises on the illegal request and the saved address is unchanged. `rst` clears all outputs and the state to IDLE.

Source files
------------

// File: rtl/l2_fwd_stall_tracker.sv
// Parks one coherence forward blocked by a transient MSHR entry and signals the
// L2 input decoder when the owning entry is released so the forward can replay.
module l2_fwd_stall_tracker #(
    parameter int unsigned LINE_ADDR_W = 28,
    parameter int unsigned PAYLOAD_W   = 16,
    parameter int unsigned MSHR_IDX_W  = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_req,
    input  logic [MSHR_IDX_W-1:0]  stall_mshr_idx,
    input  logic [LINE_ADDR_W-1:0] stall_addr,
    input  logic [PAYLOAD_W-1:0]   stall_payload,
    input  logic                   mshr_release,
    input  logic [MSHR_IDX_W-1:0]  mshr_release_idx,
    input  logic                   set_fwd_in_from_stalled,
    output logic                   fwd_stall,
    output logic                   fwd_stall_ended,
    output logic [LINE_ADDR_W-1:0] stalled_addr,
    output logic [PAYLOAD_W-1:0]   stalled_payload,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic                   timeout_err,
    output logic                   protocol_err
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StReady = 2'd2;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    logic [1:0]             state_q, state_d;
    logic [LINE_ADDR_W-1:0] addr_q, addr_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic [MSHR_IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tout_q, tout_d;
    logic                   perr_q, perr_d;

    logic accept;
    logic hit_new;
    logic hit_saved;

    // A new forward is accepted in IDLE, or in READY while the old one is being consumed.
    assign accept    = stall_req &&
                       ((state_q == StIdle) || ((state_q == StReady) && set_fwd_in_from_stalled));
    assign hit_new   = mshr_release && (mshr_release_idx == stall_mshr_idx);
    assign hit_saved = mshr_release && (mshr_release_idx == idx_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        payload_d = payload_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tout_d    = tout_q;
        perr_d    = perr_q;

        unique case (state_q)
            StIdle: ;
            StWait: begin
                if (stall_req) perr_d = 1'b1;
                if (hit_saved) begin
                    state_d = StReady;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_d >= TimeoutCnt) tout_d = 1'b1;
            end
            StReady: begin
                if (set_fwd_in_from_stalled) begin
                    state_d = StIdle;
                end else if (stall_req) begin
                    perr_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Capture overrides the per-state decisions; a same-cycle wake-up goes straight to READY.
        if (accept) begin
            addr_d    = stall_addr;
            payload_d = stall_payload;
            idx_d     = stall_mshr_idx;
            cnt_d     = '0;
            state_d   = hit_new ? StReady : StWait;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            payload_q <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            tout_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            payload_q <= payload_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            tout_q    <= tout_d;
            perr_q    <= perr_d;
        end
    end

    assign fwd_stall       = (state_q != StIdle);
    assign fwd_stall_ended = (state_q == StReady);
    assign stalled_addr    = addr_q;
    assign stalled_payload = payload_q;
    assign stall_cycles    = cnt_q;
    assign timeout_err     = tout_q;
    assign protocol_err    = perr_q;

endmodule

// File: tb/tb_l2_fwd_stall_tracker.sv
// Directed scenarios plus a randomized run checked against a cycle-level model of the stall rules.
module tb_l2_fwd_stall_tracker;

    localparam int unsigned LA = 28;
    localparam int unsigned PW = 16;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 16;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall_req = 1'b0;
    logic [IW-1:0] stall_mshr_idx = '0;
    logic [LA-1:0] stall_addr = '0;
    logic [PW-1:0] stall_payload = '0;
    logic          mshr_release = 1'b0;
    logic [IW-1:0] mshr_release_idx = '0;
    logic          set_fwd_in_from_stalled = 1'b0;
    logic          fwd_stall;
    logic          fwd_stall_ended;
    logic [LA-1:0] stalled_addr;
    logic [PW-1:0] stalled_payload;
    logic [CW-1:0] stall_cycles;
    logic          timeout_err;
    logic          protocol_err;

    int checks = 0;
    int failures = 0;

    // Model: parked = forward held; woken = released and awaiting replay.
    bit            m_parked, m_woken;
    logic [LA-1:0] m_addr;
    logic [PW-1:0] m_pay;
    logic [IW-1:0] m_idx;
    int unsigned   m_cnt;
    bit            m_tout, m_perr;

    l2_fwd_stall_tracker #(
        .LINE_ADDR_W(LA), .PAYLOAD_W(PW), .MSHR_IDX_W(IW), .CNT_W(CW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .stall_req(stall_req), .stall_mshr_idx(stall_mshr_idx),
        .stall_addr(stall_addr), .stall_payload(stall_payload),
        .mshr_release(mshr_release), .mshr_release_idx(mshr_release_idx),
        .set_fwd_in_from_stalled(set_fwd_in_from_stalled),
        .fwd_stall(fwd_stall), .fwd_stall_ended(fwd_stall_ended),
        .stalled_addr(stalled_addr), .stalled_payload(stalled_payload),
        .stall_cycles(stall_cycles), .timeout_err(timeout_err), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_parked = 0; m_woken = 0; m_addr = '0; m_pay = '0; m_idx = '0;
        m_cnt = 0; m_tout = 0; m_perr = 0;
    endtask

    task automatic model_step();
        bit consumed;
        consumed = m_parked && m_woken && set_fwd_in_from_stalled;
        if (stall_req && (!m_parked || consumed)) begin
            m_parked = 1; m_addr = stall_addr; m_pay = stall_payload; m_idx = stall_mshr_idx;
            m_cnt = 0;
            m_woken = mshr_release && (mshr_release_idx == stall_mshr_idx);
        end else begin
            if (stall_req) m_perr = 1;
            if (m_parked && !m_woken) begin
                if (mshr_release && mshr_release_idx == m_idx) m_woken = 1;
                else if (m_cnt < (2 ** CW) - 1) m_cnt++;
                if (m_cnt >= TO) m_tout = 1;
            end else if (consumed) begin
                m_parked = 0; m_woken = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_req = 0; mshr_release = 0; set_fwd_in_from_stalled = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; model_reset();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fwd_stall, fwd_stall_ended, timeout_err, protocol_err} !== 4'b0 ||
            stalled_addr !== '0 || stalled_payload !== '0 || stall_cycles !== '0) begin
            failures++;
            $display("FAIL reset_state: got stall=%b ended=%b tout=%b perr=%b addr=%h pay=%h cnt=%0d, want all 0",
                     fwd_stall, fwd_stall_ended, timeout_err, protocol_err,
                     stalled_addr, stalled_payload, stall_cycles);
        end
    endtask

    task automatic test_basic_wakeup();
        int hi = 0, en = 0;
        do_reset();
        stall_req = 1; stall_mshr_idx = 2; stall_addr = 28'h0ABCDEF; stall_payload = 16'h1234;
        tick(); stall_req = 0;
        hi += int'(fwd_stall); en += int'(fwd_stall_ended);
        for (int i = 0; i < 5; i++) begin
            tick(); hi += int'(fwd_stall); en += int'(fwd_stall_ended);
        end
        mshr_release = 1; mshr_release_idx = 2;
        tick(); mshr_release = 0;
        hi += int'(fwd_stall); en += int'(fwd_stall_ended);
        checks++;
        if (stall_cycles !== 16'd5) begin
            failures++; $display("FAIL basic_cycles: got %0d want 5", stall_cycles);
        end
        checks++;
        if (stalled_addr !== 28'h0ABCDEF || stalled_payload !== 16'h1234) begin
            failures++;
            $display("FAIL basic_saved: got addr=%h pay=%h want 0abcdef/1234",
                     stalled_addr, stalled_payload);
        end
        tick(); hi += int'(fwd_stall); en += int'(fwd_stall_ended);
        set_fwd_in_from_stalled = 1;
        tick(); set_fwd_in_from_stalled = 0;
        hi += int'(fwd_stall); en += int'(fwd_stall_ended);
        checks++;
        if (hi != 8 || en != 2) begin
            failures++; $display("FAIL basic_durations: got stall=%0d ended=%0d want 8/2", hi, en);
        end
        checks++;
        if (stalled_addr !== 28'h0ABCDEF) begin
            failures++; $display("FAIL basic_addr_kept: got %h want 0abcdef", stalled_addr);
        end
    endtask

    task automatic test_nonmatching_release();
        do_reset();
        stall_req = 1; stall_mshr_idx = 1; stall_addr = 28'h1111; stall_payload = 16'hAAAA;
        tick(); stall_req = 0;
        mshr_release = 1; mshr_release_idx = 0; tick();
        mshr_release_idx = 3; tick();
        mshr_release = 0;
        checks++;
        if (fwd_stall !== 1'b1 || fwd_stall_ended !== 1'b0) begin
            failures++;
            $display("FAIL nonmatch_wait: got stall=%b ended=%b want 1/0", fwd_stall, fwd_stall_ended);
        end
        mshr_release = 1; mshr_release_idx = 1; tick(); mshr_release = 0;
        checks++;
        if (fwd_stall !== 1'b1 || fwd_stall_ended !== 1'b1) begin
            failures++;
            $display("FAIL nonmatch_ready: got stall=%b ended=%b want 1/1", fwd_stall, fwd_stall_ended);
        end
        set_fwd_in_from_stalled = 1; tick(); set_fwd_in_from_stalled = 0;
    endtask

    task automatic test_same_cycle();
        stall_req = 1; stall_mshr_idx = 3; stall_addr = 28'h3333; stall_payload = 16'h0033;
        mshr_release = 1; mshr_release_idx = 3;
        tick(); clear_inputs();
        checks++;
        if (fwd_stall !== 1'b1 || fwd_stall_ended !== 1'b1 || stall_cycles !== '0) begin
            failures++;
            $display("FAIL same_cycle: got stall=%b ended=%b cnt=%0d want 1/1/0",
                     fwd_stall, fwd_stall_ended, stall_cycles);
        end
    endtask

    task automatic test_back_to_back();
        set_fwd_in_from_stalled = 1; stall_req = 1; stall_mshr_idx = 0;
        stall_addr = 28'h55; stall_payload = 16'h0055;
        tick(); clear_inputs();
        checks++;
        if (fwd_stall !== 1'b1 || fwd_stall_ended !== 1'b0 || stalled_addr !== 28'h55) begin
            failures++;
            $display("FAIL back_to_back: got stall=%b ended=%b addr=%h want 1/0/55",
                     fwd_stall, fwd_stall_ended, stalled_addr);
        end
        tick();
        checks++;
        if (stall_cycles !== 16'd1) begin
            failures++; $display("FAIL b2b_counting: got %0d want 1", stall_cycles);
        end
    endtask

    task automatic test_watchdog_illegal_reset();
        do_reset();
        stall_req = 1; stall_mshr_idx = 2; stall_addr = 28'h123; stall_payload = 16'h0123;
        tick(); stall_req = 0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (stall_cycles !== 16'd7 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL watchdog_pre: got cnt=%0d tout=%b want 7/0", stall_cycles, timeout_err);
        end
        tick();
        checks++;
        if (stall_cycles !== 16'd8 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL watchdog_trip: got cnt=%0d tout=%b want 8/1", stall_cycles, timeout_err);
        end
        stall_req = 1; stall_mshr_idx = 1; stall_addr = 28'h999; stall_payload = 16'h0999;
        tick(); stall_req = 0;
        checks++;
        if (protocol_err !== 1'b1 || stalled_addr !== 28'h123 || stalled_payload !== 16'h0123 ||
            fwd_stall !== 1'b1 || fwd_stall_ended !== 1'b0 || stall_cycles !== 16'd9) begin
            failures++;
            $display("FAIL illegal_req: got perr=%b addr=%h pay=%h stall=%b ended=%b cnt=%0d want 1/123/0123/1/0/9",
                     protocol_err, stalled_addr, stalled_payload, fwd_stall, fwd_stall_ended,
                     stall_cycles);
        end
        #2 rst = 1; model_reset();
        #1;
        checks++;
        if ({fwd_stall, fwd_stall_ended, timeout_err, protocol_err} !== 4'b0 ||
            stalled_addr !== '0 || stalled_payload !== '0 || stall_cycles !== '0) begin
            failures++;
            $display("FAIL async_reset: got stall=%b ended=%b tout=%b perr=%b addr=%h cnt=%0d want all 0",
                     fwd_stall, fwd_stall_ended, timeout_err, protocol_err, stalled_addr,
                     stall_cycles);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            stall_req               = ($urandom_range(0, 2) == 0);
            stall_mshr_idx          = IW'($urandom);
            stall_addr              = LA'($urandom);
            stall_payload           = PW'($urandom);
            mshr_release            = ($urandom_range(0, 2) == 0);
            mshr_release_idx        = IW'($urandom);
            set_fwd_in_from_stalled = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (fwd_stall !== m_parked || fwd_stall_ended !== (m_parked && m_woken) ||
                stalled_addr !== m_addr || stalled_payload !== m_pay ||
                stall_cycles !== CW'(m_cnt) || timeout_err !== m_tout || protocol_err !== m_perr) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random_c%0d: got stall=%b ended=%b addr=%h pay=%h cnt=%0d tout=%b perr=%b want %b/%b/%h/%h/%0d/%b/%b",
                             c, fwd_stall, fwd_stall_ended, stalled_addr, stalled_payload,
                             stall_cycles, timeout_err, protocol_err, m_parked,
                             m_parked && m_woken, m_addr, m_pay, m_cnt, m_tout, m_perr);
                bad++;
            end
            if (c % 150 == 149) begin
                clear_inputs();
                do_reset();
            end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_wakeup();
        test_nonmatching_release();
        test_same_cycle();
        test_back_to_back();
        test_watchdog_illegal_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
